fir_output_decimator: RTL and testbench

Downstream stage of the pipelined FIR filter. It consumes the full-precision filter output, keeps one of every DECIM samples, then rounds and saturates each kept sample to OUT_WIDTH. Results are buffered in a small first-word-fall-through FIFO, and the consumer pulls them with a valid/ready handshake. Two sticky status flags report saturation and dropped samples.

---
 rtl/fir_output_decimator.sv | 138 +++++++++++++
 tb/tb_fir_output_decimator.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/fir_output_decimator.sv
// Decimates the full-precision FIR output, rounds half-up and saturates each kept sample,
// and buffers results in a first-word-fall-through FIFO drained by a valid/ready consumer.
module fir_output_decimator #(
   parameter int IN_WIDTH   = 40,
   parameter int OUT_WIDTH  = 16,
   parameter int DECIM      = 4,
   parameter int FRAC_DROP  = 24,
   parameter int FIFO_DEPTH = 8
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          in_valid,
   input  logic [IN_WIDTH-1:0]           in_data,
   output logic                          out_valid,
   input  logic                          out_ready,
   output logic [OUT_WIDTH-1:0]          out_data,
   output logic                          sat_flag,
   output logic                          ovf_flag,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

   localparam int PW = (DECIM > 1) ? $clog2(DECIM) : 1;
   localparam int RW = IN_WIDTH + 1 - FRAC_DROP;
   localparam int AW = $clog2(FIFO_DEPTH);
   localparam logic [PW-1:0] PH_LAST = PW'(DECIM - 1);

   // Half-LSB rounding constant; all zeros when nothing is dropped.
   function automatic logic [IN_WIDTH:0] round_const();
      logic [IN_WIDTH:0] r;
      r = '0;
      for (int i = 0; i <= IN_WIDTH; i++) begin
         r[i] = (i == FRAC_DROP - 1);
      end
      return r;
   endfunction

   localparam logic [IN_WIDTH:0] RND_ADD = round_const();

   // Returns {saturated, value}: clamps when the bits above the output sign disagree.
   function automatic logic [OUT_WIDTH:0] saturate(input logic [RW-1:0] v);
      logic [RW-OUT_WIDTH:0] top;
      top = v[RW-1:OUT_WIDTH-1];
      if ((top == '0) || (top == '1)) begin
         return {1'b0, v[OUT_WIDTH-1:0]};
      end else if (v[RW-1]) begin
         return {1'b1, 1'b1, {(OUT_WIDTH-1){1'b0}}};
      end else begin
         return {1'b1, 1'b0, {(OUT_WIDTH-1){1'b1}}};
      end
   endfunction

   logic [PW-1:0]        phase_q, phase_d;
   logic                 s1_valid_q, s1_valid_d;
   logic [RW-1:0]        s1_data_q, s1_data_d;
   logic                 s2_valid_q, s2_valid_d;
   logic [OUT_WIDTH-1:0] s2_data_q, s2_data_d;
   logic                 sat_q, sat_d;
   logic                 ovf_q, ovf_d;
   logic [AW-1:0]        wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]        rd_ptr_q, rd_ptr_d;
   logic [AW:0]          level_q, level_d;
   logic [OUT_WIDTH-1:0] mem_q [FIFO_DEPTH];

   logic [IN_WIDTH:0]    ext_sum_s;
   logic [OUT_WIDTH:0]   sat_res_s;
   logic                 full_s, rd_en_s, wr_en_s;
   logic                 unused_s;

   // Next-state logic for decimation, both pipeline stages, flags and FIFO bookkeeping.
   always_comb begin
      ext_sum_s  = {in_data[IN_WIDTH-1], in_data} + RND_ADD;
      phase_d    = phase_q;
      if (in_valid) begin
         phase_d = (phase_q == PH_LAST) ? '0 : phase_q + PW'(1);
      end else begin
         phase_d = phase_q;
      end
      s1_valid_d = in_valid && (phase_q == '0);
      s1_data_d  = ext_sum_s[IN_WIDTH:FRAC_DROP];

      sat_res_s  = saturate(s1_data_q);
      s2_valid_d = s1_valid_q;
      s2_data_d  = sat_res_s[OUT_WIDTH-1:0];
      sat_d      = sat_q | (s1_valid_q & sat_res_s[OUT_WIDTH]);

      // A full FIFO still accepts a write when the head leaves on the same edge.
      full_s     = (level_q == (AW+1)'(FIFO_DEPTH));
      rd_en_s    = (level_q != '0) && out_ready;
      wr_en_s    = s2_valid_q && (!full_s || rd_en_s);
      ovf_d      = ovf_q | (s2_valid_q & full_s & ~rd_en_s);
      wr_ptr_d   = wr_en_s ? wr_ptr_q + AW'(1) : wr_ptr_q;
      rd_ptr_d   = rd_en_s ? rd_ptr_q + AW'(1) : rd_ptr_q;
      level_d    = level_q + (AW+1)'(wr_en_s) - (AW+1)'(rd_en_s);
   end

   assign unused_s = ^ext_sum_s;

   // State registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         phase_q    <= '0;
         s1_valid_q <= 1'b0;
         s1_data_q  <= '0;
         s2_valid_q <= 1'b0;
         s2_data_q  <= '0;
         sat_q      <= 1'b0;
         ovf_q      <= 1'b0;
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         level_q    <= '0;
      end else begin
         phase_q    <= phase_d;
         s1_valid_q <= s1_valid_d;
         s1_data_q  <= s1_data_d;
         s2_valid_q <= s2_valid_d;
         s2_data_q  <= s2_data_d;
         sat_q      <= sat_d;
         ovf_q      <= ovf_d;
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         level_q    <= level_d;
      end
   end

   // FIFO storage; contents are qualified by level so no reset is needed.
   always_ff @(posedge clk) begin
      if (!rst && wr_en_s) begin
         mem_q[wr_ptr_q] <= s2_data_q;
      end
   end

   assign out_valid  = (level_q != '0);
   assign out_data   = out_valid ? mem_q[rd_ptr_q] : '0;
   assign sat_flag   = sat_q;
   assign ovf_flag   = ovf_q;
   assign fifo_level = level_q;

endmodule

// File: tb/tb_fir_output_decimator.sv
// Directed scoreboard bench: DUT a uses default parameters, DUT b runs with DECIM=1.
module tb_fir_output_decimator;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        a_rst, a_in_valid, a_out_valid, a_out_ready, a_sat, a_ovf;
   logic [39:0] a_in_data;
   logic [15:0] a_out_data;
   logic [3:0]  a_level;
   logic        b_rst, b_in_valid, b_out_valid, b_out_ready, b_sat, b_ovf;
   logic [39:0] b_in_data;
   logic [15:0] b_out_data;
   logic [3:0]  b_level;

   fir_output_decimator dut_a (
      .clk(clk), .rst(a_rst), .in_valid(a_in_valid), .in_data(a_in_data),
      .out_valid(a_out_valid), .out_ready(a_out_ready), .out_data(a_out_data),
      .sat_flag(a_sat), .ovf_flag(a_ovf), .fifo_level(a_level)
   );

   fir_output_decimator #(.DECIM(1)) dut_b (
      .clk(clk), .rst(b_rst), .in_valid(b_in_valid), .in_data(b_in_data),
      .out_valid(b_out_valid), .out_ready(b_out_ready), .out_data(b_out_data),
      .sat_flag(b_sat), .ovf_flag(b_ovf), .fifo_level(b_level)
   );

   int errors = 0;
   int checks = 0;
   logic [15:0] q_a[$];
   logic [15:0] q_b[$];

   task automatic chk(input string tag, input logic [39:0] obs, input logic [39:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic b_step(input logic [39:0] d, input logic [15:0] e, input logic keep);
      b_in_valid = 1'b1;
      b_in_data  = d;
      if (keep) q_b.push_back(e);
      cyc();
   endtask

   task automatic b_idle(input int n);
      b_in_valid = 1'b0;
      repeat (n) cyc();
   endtask

   task automatic reset_b();
      b_rst      = 1'b1;
      b_in_valid = 1'b0;
      cyc();
      b_rst = 1'b0;
      q_b.delete();
   endtask

   // Scoreboard pop for DUT a at each transfer.
   always @(negedge clk) begin
      if (!a_rst && a_out_valid && a_out_ready) begin
         checks++;
         assert (q_a.size() != 0) else begin
            errors++;
            $error("FAIL a_sb: observed unexpected output %0h expected none", a_out_data);
         end
         if (q_a.size() != 0) chk("a_out", {24'd0, a_out_data}, {24'd0, q_a.pop_front()});
      end
   end

   // Scoreboard pop for DUT b at each transfer.
   always @(negedge clk) begin
      if (!b_rst && b_out_valid && b_out_ready) begin
         checks++;
         assert (q_b.size() != 0) else begin
            errors++;
            $error("FAIL b_sb: observed unexpected output %0h expected none", b_out_data);
         end
         if (q_b.size() != 0) chk("b_out", {24'd0, b_out_data}, {24'd0, q_b.pop_front()});
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: observed timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      a_rst = 1'b1; a_in_valid = 1'b0; a_in_data = 40'd0; a_out_ready = 1'b0;
      b_rst = 1'b1; b_in_valid = 1'b0; b_in_data = 40'd0; b_out_ready = 1'b0;
      repeat (2) cyc();
      a_rst = 1'b0;
      b_rst = 1'b0;

      // Reset state
      chk("a_rst_valid", a_out_valid, 40'd0);
      chk("a_rst_data",  a_out_data,  40'd0);
      chk("a_rst_sat",   a_sat,       40'd0);
      chk("a_rst_ovf",   a_ovf,       40'd0);
      chk("a_rst_level", a_level,     40'd0);
      chk("b_rst_valid", b_out_valid, 40'd0);
      chk("b_rst_data",  b_out_data,  40'd0);
      chk("b_rst_level", b_level,     40'd0);

      // Test 1: decimate by 4 with latency check
      a_out_ready = 1'b1;
      for (int k = 0; k < 16; k++) begin
         a_in_valid = 1'b1;
         a_in_data  = 40'(k) << 24;
         if (k % 4 == 0) q_a.push_back(16'(k));
         cyc();
         if (k < 2) chk("a_latency_early", a_out_valid, 40'd0);
         else if (k == 2) chk("a_latency_first", a_out_valid, 40'd1);
      end
      a_in_valid = 1'b0;
      repeat (6) cyc();
      chk("a_t1_sat",   a_sat, 40'd0);
      chk("a_t1_ovf",   a_ovf, 40'd0);
      chk("a_t1_drain", 40'(q_a.size()), 40'd0);

      // Test 2: rounding
      b_out_ready = 1'b1;
      b_step(40'h0000800000, 16'h0001, 1'b1);
      b_step(40'h00007FFFFF, 16'h0000, 1'b1);
      b_step(40'hFFFF800000, 16'h0000, 1'b1);
      b_step(40'hFFFF7FFFFF, 16'hFFFF, 1'b1);
      b_step(40'h0001800000, 16'h0002, 1'b1);
      b_idle(5);
      chk("b_t2_drain", 40'(q_b.size()), 40'd0);
      chk("b_t2_sat",   b_sat, 40'd0);

      // Test 3: saturation
      b_step(40'h7FFFFFFFFF, 16'h7FFF, 1'b1);
      chk("b_t3_sat_pre", b_sat, 40'd0);
      b_step(40'h8000000000, 16'h8000, 1'b1);
      chk("b_t3_sat_set", b_sat, 40'd1);
      b_step(40'h0000000000, 16'h0000, 1'b1);
      b_idle(5);
      chk("b_t3_sat_sticky", b_sat, 40'd1);
      chk("b_t3_drain", 40'(q_b.size()), 40'd0);

      // Test 4: backpressure and overflow
      reset_b();
      b_out_ready = 1'b0;
      for (int k = 1; k <= 10; k++) begin
         b_step(40'(k) << 24, 16'(k), (k <= 8));
      end
      b_idle(4);
      chk("b_t4_level", b_level,     40'd8);
      chk("b_t4_ovf",   b_ovf,       40'd1);
      chk("b_t4_valid", b_out_valid, 40'd1);
      chk("b_t4_head",  b_out_data,  40'd1);
      b_idle(2);
      chk("b_t4_hold",  b_out_data,  40'd1);
      b_out_ready = 1'b1;
      b_idle(10);
      chk("b_t4_empty_valid", b_out_valid, 40'd0);
      chk("b_t4_empty_data",  b_out_data,  40'd0);
      chk("b_t4_empty_level", b_level,     40'd0);
      chk("b_t4_drain",       40'(q_b.size()), 40'd0);
      chk("b_t4_ovf_sticky",  b_ovf,       40'd1);

      // Test 5: full FIFO with simultaneous read and write
      reset_b();
      b_out_ready = 1'b0;
      for (int k = 0; k < 8; k++) begin
         b_step(40'(100 + k) << 24, 16'(100 + k), 1'b1);
      end
      b_idle(3);
      chk("b_t5_full", b_level, 40'd8);
      b_step(40'(108) << 24, 16'd108, 1'b1);
      b_in_valid = 1'b0;
      cyc();
      b_out_ready = 1'b1;
      cyc();
      b_out_ready = 1'b0;
      chk("b_t5_level_rw", b_level, 40'd8);
      chk("b_t5_ovf",      b_ovf,   40'd0);
      b_out_ready = 1'b1;
      b_idle(12);
      chk("b_t5_drain", 40'(q_b.size()), 40'd0);

      // Test 6: reset mid-stream
      reset_b();
      b_out_ready = 1'b0;
      b_step(40'h7FFFFFFFFF, 16'h0000, 1'b0);
      for (int k = 1; k < 7; k++) begin
         b_step(40'(k) << 24, 16'(k), 1'b0);
      end
      chk("b_t6_pre_level", b_level, 40'd5);
      chk("b_t6_pre_sat",   b_sat,   40'd1);
      b_in_valid = 1'b1;
      b_in_data  = 40'(7) << 24;
      b_rst      = 1'b1;
      cyc();
      b_rst      = 1'b0;
      b_in_valid = 1'b0;
      chk("b_t6_valid", b_out_valid, 40'd0);
      chk("b_t6_level", b_level,     40'd0);
      chk("b_t6_sat",   b_sat,       40'd0);
      chk("b_t6_ovf",   b_ovf,       40'd0);
      b_idle(4);
      chk("b_t6_flush", b_level, 40'd0);
      b_out_ready = 1'b1;
      b_step(40'(9) << 24, 16'd9, 1'b1);
      b_idle(5);
      chk("b_t6_drain", 40'(q_b.size()), 40'd0);

      // Phase restarts at zero after a mid-stream reset
      a_in_valid = 1'b1;
      a_in_data  = 40'(50) << 24;
      cyc();
      a_in_data  = 40'(51) << 24;
      cyc();
      a_in_data  = 40'(52) << 24;
      a_rst      = 1'b1;
      cyc();
      a_rst = 1'b0;
      chk("a_t6_valid", a_out_valid, 40'd0);
      chk("a_t6_level", a_level,     40'd0);
      for (int k = 77; k < 82; k++) begin
         a_in_data = 40'(k) << 24;
         if (k == 77 || k == 81) q_a.push_back(16'(k));
         cyc();
      end
      a_in_valid = 1'b0;
      repeat (6) cyc();
      chk("a_t6_drain", 40'(q_a.size()), 40'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
